// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM-stage data accesses onto one single-port memory,
// returning a one-cycle ack per access and stall requests until each requester is served.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W/8-1:0] dm_sel,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stallreq_if,
  output logic                stallreq_dm,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STR_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [STR_W-1:0]    r_streak;
  logic                r_wr;
  logic                r_if_ack, r_dm_ack;
  logic [DATA_W-1:0]   r_if_rdata, r_dm_rdata;
  logic                r_mem_en, r_mem_we;
  logic [DATA_W/8-1:0] r_mem_sel;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                w_starved, w_grant_if, w_grant_dm;
  logic [STR_W-1:0]    w_streak_dm;
  assign w_starved   = r_streak == STR_W'(STARVE_MAX);
  assign w_grant_if  = if_req & (~dm_req | w_starved);
  assign w_grant_dm  = dm_req & ~w_grant_if;
  // a DM grant only extends the streak while IF is actually waiting
  assign w_streak_dm = ~if_req ? '0 : w_starved ? r_streak : r_streak + 1'b1;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_wr        <= 1'b0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_sel   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_sel   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      if (r_state == IDLE) begin
        if (w_grant_if | w_grant_dm) begin
          r_state     <= w_grant_if ? BUSY_IF : BUSY_DM;
          r_cnt       <= '0;
          r_wr        <= w_grant_dm & dm_we;
          r_mem_en    <= 1'b1;
          r_mem_we    <= w_grant_dm & dm_we;
          r_mem_sel   <= w_grant_if ? '1 : dm_sel;
          r_mem_addr  <= w_grant_if ? if_addr : dm_addr;
          r_mem_wdata <= w_grant_if ? '0 : dm_wdata;
          r_streak    <= w_grant_if ? '0 : w_streak_dm;
        end
      end else if (r_cnt == CNT_W'(MEM_LAT)) begin
        r_state  <= IDLE;
        r_if_ack <= r_state == BUSY_IF;
        r_dm_ack <= r_state == BUSY_DM;
        if (r_state == BUSY_IF) r_if_rdata <= mem_rdata;
        if (r_state == BUSY_DM && !r_wr) r_dm_rdata <= mem_rdata;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign if_ack      = r_if_ack;
  assign dm_ack      = r_dm_ack;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_sel     = r_mem_sel;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_state != IDLE;
  assign stallreq_if = if_req & ~r_if_ack;
  assign stallreq_dm = dm_req & ~r_dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, plus a transaction-level
// schedule model of the arbiter checked against the DUT on every cycle.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  logic        clk = 1'b0, resetn = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_sel = '0;
  logic        if_ack, dm_ack, stallreq_if, stallreq_dm, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  int          checks = 0, failures = 0, cyc = 0, t0 = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rsp [int];
  bit          mlog [$];
  int          g_cyc = -100, streak = 0;
  bit          g_if, g_we;
  logic [31:0] g_addr, g_wdata, e_ifd = '0, e_dmd = '0;
  logic [3:0]  g_sel;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stallreq_if(stallreq_if), .stallreq_dm(stallreq_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mrd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", n, cyc, a, e);
    end
  endtask

  // memory: read data appears MEM_LAT cycles after the strobe, garbage otherwise
  always @(negedge clk) begin
    logic [31:0] w;
    mem_rdata = rsp.exists(cyc) ? rsp[cyc] : (32'hBAD00000 ^ 32'(cyc));
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        w = mrd(mem_addr);
        for (int k = 0; k < 4; k++) if (mem_sel[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
        mem[mem_addr] = w;
      end else begin
        rsp[cyc + LAT] = mrd(mem_addr);
      end
    end
  end

  // model: each grant schedules a strobe cycle and an ack cycle; the arbiter is free from the ack on
  always @(negedge clk) begin
    bit en, ak, tif;
    if (resetn) begin
      g_cyc = -100;
      e_ifd = '0;
      e_dmd = '0;
      streak = 0;
    end
    en = cyc == g_cyc;
    ak = cyc == g_cyc + LAT + 1;
    if (ak && g_if) e_ifd = mrd(g_addr);
    if (ak && !g_if && !g_we) e_dmd = mrd(g_addr);
    chk("m.mem_en", mem_en, en);
    chk("m.mem_we", mem_we, en & g_we);
    chk("m.mem_sel", mem_sel, en ? g_sel : 4'h0);
    chk("m.mem_addr", mem_addr, en ? g_addr : 32'h0);
    chk("m.mem_wdata", mem_wdata, en ? g_wdata : 32'h0);
    chk("m.if_ack", if_ack, ak & g_if);
    chk("m.dm_ack", dm_ack, ak & !g_if);
    chk("m.if_rdata", if_rdata, e_ifd);
    chk("m.dm_rdata", dm_rdata, e_dmd);
    chk("m.busy", busy, cyc >= g_cyc && cyc <= g_cyc + LAT);
    chk("m.stall_if", stallreq_if, if_req & !(ak & g_if));
    chk("m.stall_dm", stallreq_dm, dm_req & !(ak & !g_if));
    if (!resetn && cyc > g_cyc + LAT && (if_req || dm_req)) begin
      tif = if_req && (!dm_req || streak == SMAX);
      streak = (tif || !if_req) ? 0 : (streak < SMAX ? streak + 1 : SMAX);
      mlog.push_back(tif);
      g_cyc   = cyc + 1;
      g_if    = tif;
      g_we    = !tif && dm_we;
      g_addr  = tif ? if_addr : dm_addr;
      g_sel   = tif ? 4'hF : dm_sel;
      g_wdata = tif ? 32'h0 : dm_wdata;
    end
  end

  task automatic to_neg(int c);
    do @(negedge clk); while (cyc < t0 + c);
  endtask
  task automatic to_pos(int c);
    do begin @(posedge clk); #1; end while (cyc < t0 + c);
  endtask
  task automatic start();
    @(posedge clk); #1;
    t0 = cyc;
  endtask
  task automatic idle(int n);
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, base;
    logic [5:0] seq, mseq;
    mem[32'h100] = 32'h2402000A;
    mem[32'h104] = 32'h00001104;
    mem[32'h10C] = 32'hCAFE0001;
    mem[32'h204] = 32'h11223344;
    mem[32'h300] = 32'hA0A00300;
    mem[32'h400] = 32'h12345678;
    // T1: reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if_req   = 1'($urandom_range(0, 1));
      dm_req   = 1'($urandom_range(0, 1));
      dm_we    = 1'($urandom_range(0, 1));
      if_addr  = $urandom;
      dm_addr  = $urandom;
      dm_sel   = 4'($urandom_range(0, 15));
      dm_wdata = $urandom;
      @(negedge clk);
      chk("T1 mem_en", mem_en, 0);
      chk("T1 mem_addr", mem_addr, 0);
      chk("T1 busy", busy, 0);
      chk("T1 acks", {if_ack, dm_ack}, 0);
      chk("T1 if_rdata", if_rdata, 0);
      chk("T1 dm_rdata", dm_rdata, 0);
      chk("T1 stall_if", stallreq_if, if_req);
      chk("T1 stall_dm", stallreq_dm, dm_req);
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; resetn = 1'b0;
    idle(2);
    // T2: single fetch; request kept through its ack becomes a second fetch
    start();
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 4; c++) begin
      to_neg(c);
      chk("T2 stall_if", stallreq_if, c < 4);
      chk("T2 if_ack", if_ack, c == 4);
      if (c == 1) begin
        chk("T2 mem_en", mem_en, 1);
        chk("T2 mem_addr", mem_addr, 32'h100);
      end
    end
    chk("T2 if_rdata", if_rdata, 32'h2402000A);
    to_pos(5);
    if_req = 1'b0;
    idle(6);
    // T3: simultaneous requests, DM first
    start();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_sel = 4'hF;
    for (int c = 0; c <= 8; c++) begin
      if (c == 4) begin to_pos(4); dm_req = 1'b0; end
      if (c == 8) begin to_pos(8); if_req = 1'b0; end
      to_neg(c);
      chk("T3 stall_if", stallreq_if, c < 8);
      chk("T3 mem_en", mem_en, c == 1 || c == 5);
      chk("T3 dm_ack", dm_ack, c == 4);
      chk("T3 if_ack", if_ack, c == 8);
      if (c == 1) chk("T3 dm mem_addr", mem_addr, 32'h300);
      if (c == 5) begin
        chk("T3 if mem_addr", mem_addr, 32'h104);
        chk("T3 if mem_sel", mem_sel, 4'hF);
      end
    end
    chk("T3 dm_rdata", dm_rdata, 32'hA0A00300);
    chk("T3 if_rdata", if_rdata, 32'h00001104);
    idle(2);
    // T4: starvation limit, grant order D D D D I D (bit k = 1 when grant k is IF)
    start();
    base = mlog.size();
    if_req = 1'b1; if_addr = 32'h108;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_sel = 4'hF;
    n = 0; seq = '0; mseq = '0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      to_neg(c);
      if (if_ack || dm_ack) begin
        seq[n] = if_ack;
        n++;
      end
    end
    chk("T4 ack count", n, 6);
    chk("T4 dut order", seq, 6'b010000);
    for (int k = 0; k < 6; k++) if (base + k < mlog.size()) mseq[k] = mlog[base + k];
    chk("T4 model order", mseq, 6'b010000);
    idle(8);
    // T5: partial write, then read it back
    start();
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011; dm_addr = 32'h204; dm_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) begin to_pos(4); dm_req = 1'b0; dm_we = 1'b0; end
      to_neg(c);
      chk("T5 dm_ack", dm_ack, c == 4);
      if (c == 1) begin
        chk("T5 mem_en", mem_en, 1);
        chk("T5 mem_we", mem_we, 1);
        chk("T5 mem_sel", mem_sel, 4'b0011);
        chk("T5 mem_addr", mem_addr, 32'h204);
        chk("T5 mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
    end
    chk("T5 dm_rdata kept", dm_rdata, 32'h12345678);
    idle(2);
    start();
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h204;
    to_pos(4);
    dm_req = 1'b0;
    to_neg(4);
    chk("T5 readback ack", dm_ack, 1);
    chk("T5 readback data", dm_rdata, 32'h1122BEEF);
    idle(2);
    // T6: reset in the middle of a fetch
    start();
    if_req = 1'b1; if_addr = 32'h10C;
    for (int c = 0; c <= 7; c++) begin
      if (c == 2) begin to_pos(2); resetn = 1'b1; end
      if (c == 3) begin to_pos(3); resetn = 1'b0; end
      if (c == 7) begin to_pos(7); if_req = 1'b0; end
      to_neg(c);
      chk("T6 if_ack", if_ack, c == 7);
      chk("T6 mem_en", mem_en, c == 1 || c == 4);
      if (c == 2) begin
        chk("T6 busy in reset", busy, 0);
        chk("T6 if_rdata in reset", if_rdata, 0);
        chk("T6 dm_rdata in reset", dm_rdata, 0);
        chk("T6 stall_if in reset", stallreq_if, 1);
      end
    end
    chk("T6 if_rdata", if_rdata, 32'hCAFE0001);
    idle(2);
    // T7: request dropped before its ack still completes
    start();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_sel = 4'hF;
    to_pos(1);
    dm_req = 1'b0;
    to_neg(4);
    chk("T7 dm_ack", dm_ack, 1);
    chk("T7 dm_rdata", dm_rdata, 32'hA0A00300);
    idle(2);
    // T8: random requesters that hold until ack, model-checked
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (if_ack && $urandom_range(0, 3) != 0) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (dm_ack && $urandom_range(0, 3) != 0) dm_req = 1'b0;
      else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'($urandom_range(0, 255)) << 2;
        dm_sel   = 4'($urandom_range(0, 15));
        dm_wdata = $urandom;
      end
    end
    idle(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1);
  end
endmodule
